aes_inv_key_expansion: RTL and testbench



---
 rtl/aes_inv_key_expansion.sv | 176 +++++++++++++++++
 tb/tb_aes_inv_key_expansion.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_expansion.sv
// Byte-serial AES-128 inverse key schedule: loads the round-NR key, emits round keys NR..0.
// Define AES_INV_KEY_SKIP_LAST_EN to skip re-emitting the loaded key (first output is round NR-1).
module aes_inv_key_expansion #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [7:0] rk_out,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_round,
  output logic       rk_last,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned NB = 16;

  typedef enum logic [1:0] {IDLE, EMIT, DERIVE} state_t;

  state_t        state;
  logic [DW-1:0] bank [NB];
  logic [IW-1:0] idx;
  logic [IW-1:0] round;

  logic [IW-1:0] derive_j;
  logic [IW-1:0] m_sel;
  logic [DW-1:0] sbox_out;
  logic [DW-1:0] rcon_val;
  logic [DW-1:0] derive_byte;

  function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] p;
    logic [DW-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: inverse in GF(2^8) as a^254, followed by the affine transform.
  function automatic logic [DW-1:0] sbox(input logic [DW-1:0] a);
    logic [DW-1:0] sq;
    logic [DW-1:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [DW-1:0] rcon(input logic [IW-1:0] i);
    logic [DW-1:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Derive step: idx 0..11 undo the word chaining (j=15..4), idx 12..15 undo the g() term (j=0..3).
  always_comb begin
    derive_j    = '0;
    m_sel       = 4'd12;
    derive_byte = '0;
    rcon_val    = rcon(IW'(round - 4'd1));
    if (idx < 4'd12) begin
      derive_j    = 4'd15 - idx;
      derive_byte = bank[derive_j] ^ bank[derive_j - 4'd4];
    end else begin
      derive_j    = idx - 4'd12;
      m_sel       = 4'd12 + ((derive_j + 4'd1) & 4'd3);
      derive_byte = bank[derive_j] ^ sbox_out ^ ((derive_j == 4'd0) ? rcon_val : 8'h00);
    end
  end

  assign sbox_out = sbox(bank[m_sel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      round     <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      done      <= 1'b0;
      rk_out    <= '0;
      rk_round  <= '0;
      for (int i = 0; i < int'(NB); i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            bank[idx] <= key_in;
            idx       <= idx + 4'd1;
            if (idx == 4'd15) begin
              idx       <= '0;
              round     <= IW'(NR);
              key_ready <= 1'b0;
`ifdef AES_INV_KEY_SKIP_LAST_EN
              state     <= DERIVE;
`else
              state     <= EMIT;
              rk_valid  <= 1'b1;
              rk_out    <= bank[0];
              rk_round  <= IW'(NR);
              rk_last   <= 1'b0;
`endif
            end
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx == 4'd15) begin
              idx      <= '0;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              if (round == 4'd0) begin
                done      <= 1'b1;
                key_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= DERIVE;
              end
            end else begin
              idx     <= idx + 4'd1;
              rk_out  <= bank[idx + 4'd1];
              rk_last <= (idx == 4'd14);
            end
          end
        end
        DERIVE: begin
          bank[derive_j] <= derive_byte;
          idx            <= idx + 4'd1;
          if (idx == 4'd15) begin
            idx      <= '0;
            round    <= round - 4'd1;
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_out   <= bank[0];
            rk_round <= round - 4'd1;
            rk_last  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          key_ready <= 1'b1;
          rk_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed self-checking bench for aes_inv_key_expansion (FIPS-197 A.1 round keys).
module tb_aes_inv_key_expansion;

`ifdef AES_INV_KEY_SKIP_LAST_EN
  localparam int FIRST = 9;
  localparam int SKIP_CYC = 16;
`else
  localparam int FIRST = 10;
  localparam int SKIP_CYC = 0;
`endif

  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam logic [7:0] RCON [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] rk_out;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] rk_round;
  logic       rk_last;
  logic       done;

  logic [127:0] exp_rk [0:10];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_inv_key_expansion #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round),
    .rk_last(rk_last), .done(done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_fips();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = FIPS_R10;
  endtask

  // Word-level software inverse schedule: key r -> key r-1.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    t  = t ^ {RCON[r-1], 24'h0};
    w0 = w0 ^ t;
    return {w0, w1, w2, w3};
  endfunction

  task automatic set_model(input logic [127:0] k10);
    exp_rk[10] = k10;
    for (int r = 10; r >= 1; r--) exp_rk[r-1] = inv_step(exp_rk[r], r);
  endtask

  task automatic load_key(input logic [127:0] k, input bit gap);
    for (int i = 0; i < 16; i++) begin
      int w = 0;
      key_valid = 1'b1;
      key_in    = k[127-8*i -: 8];
      while (!key_ready && w < 100) begin
        @(posedge clk); #1; w++;
      end
      if (!key_ready) check("load_ready_timeout", 128'(key_ready), 128'(1));
      if (i == 15) check("rk_valid_before_last_beat", 128'(rk_valid), 128'(0));
      @(posedge clk); #1;
      key_valid = 1'b0;
      if (gap && i == 7) repeat (3) begin @(posedge clk); #1; end
    end
`ifdef AES_INV_KEY_SKIP_LAST_EN
    check("rk_valid_after_load_skip", 128'(rk_valid), 128'(0));
`else
    check("rk_valid_after_load", 128'(rk_valid), 128'(1));
`endif
  endtask

  // Collects every emitted key against exp_rk, optionally throttling rk_ready.
  task automatic run_sched(input bit stall);
    int r = FIRST, b = 0, cyc = 0, lasts = 0;
    bit held = 0;
    logic [127:0] acc = '0;
    logic [7:0] h_out = '0;
    logic [3:0] h_rnd = '0;
    while (r >= 0 && cyc < 4000) begin
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid) begin
        if (held) begin
          check("stall_hold_rk_out", 128'(rk_out), 128'(h_out));
          check("stall_hold_rk_round", 128'(rk_round), 128'(h_rnd));
        end
        held = 0;
        if (rk_ready) begin
          check("rk_round", 128'(rk_round), 128'(r));
          check("rk_last", 128'(rk_last), 128'(b == 15));
          if (rk_last) lasts++;
          acc[127-8*b -: 8] = rk_out;
          if (b == 15) begin
            check($sformatf("key_round_%0d", r), acc, exp_rk[r]);
            b = 0;
            r--;
          end else begin
            b++;
          end
        end else begin
          held  = 1;
          h_out = rk_out;
          h_rnd = rk_round;
        end
      end
      if (done) check("done_early", 128'(done), 128'(0));
      @(posedge clk); #1;
      cyc++;
    end
    rk_ready = 1'b1;
    check("schedule_complete", 128'(r < 0), 128'(1));
    check("rk_last_count", 128'(lasts), 128'(FIRST + 1));
    if (!stall) check("schedule_cycles", 128'(cyc), 128'(32 * (FIRST + 1) - 16 + SKIP_CYC));
    check("done_pulse", 128'(done), 128'(1));
    check("key_ready_at_done", 128'(key_ready), 128'(1));
    @(posedge clk); #1;
    check("done_clear", 128'(done), 128'(0));
    check("key_ready_after_done", 128'(key_ready), 128'(1));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_key_ready", 128'(key_ready), 128'(1));
    check("reset_rk_valid", 128'(rk_valid), 128'(0));
    check("reset_rk_last", 128'(rk_last), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_rk_out", 128'(rk_out), 128'(0));
    check("reset_rk_round", 128'(rk_round), 128'(0));
    rst = 1'b0;

    set_fips();
    load_key(FIPS_R10, 1'b0);
    run_sched(1'b0);

    load_key(FIPS_R10, 1'b0);
    run_sched(1'b1);

    load_key(FIPS_R10, 1'b1);
    run_sched(1'b0);

    // Abort partway through the schedule, then reload.
    load_key(FIPS_R10, 1'b0);
    repeat (117) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rk_valid", 128'(rk_valid), 128'(0));
    check("midrst_key_ready", 128'(key_ready), 128'(1));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_rk_last", 128'(rk_last), 128'(0));
    rst = 1'b0;
    load_key(FIPS_R10, 1'b0);
    run_sched(1'b0);

    // Back-to-back: all-zero round-10 key straight after done.
    set_model(128'h0);
    load_key(128'h0, 1'b0);
    run_sched(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
